ctrl_plane_responder: RTL and testbench
=======================================

# ctrl_plane_responder

Word-addressed Avalon-MM slave that terminates control-plane accesses arriving from the PMBus-side address alignment bridge. It implements a small register file: ID, scratch, event latch with write-1-to-clear, event mask, and a bank of control outputs. Every access completes through a registered waitrequest handshake with a programmable number of wait cycles. It sits at the end of the control-plane path and feeds control bits and an interrupt to the sequencer core.

## Interface
- ID_VALUE, 32'h5EC0_0001: constant returned by the ID register.
- WAIT_CYCLES, 1: extra wait states per access. Legal range 0..15.
- NUM_CTRL, 4: number of 32-bit control registers. Legal range 1..8.
- Clock and reset (already decided): one clock, CLOCK; reset is asynchronous and active-low, RESET_N.
- CLOCK  in  1  sole clock; all state is updated on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- AVS_S0_READ  in  1  read request.
- AVS_S0_WRITE  in  1  write request.
- AVS_S0_ADDRESS  in  8  word address.
- AVS_S0_BYTEEN  in  4  byte enables; apply to writes only.
- AVS_S0_WRITEDATA  in  32  write data.
- AVS_S0_READDATA  out  32  read data; valid in the cycle WAITREQUEST is low after a read.
- AVS_S0_WAITREQUEST  out  1  high = command held; low for exactly one cycle = command accepted.
- EVENT_IN  in  32  synchronous event strobes; sampled every cycle.
- CTRL_OUT  out  32*NUM_CTRL  concatenated control registers; CTRL[0] occupies bits [31:0].
- IRQ  out  1  registered OR of (EVENT & EVENT_MASK).

## Operation
- Register map (word addresses):
  - 0x00 ID: read-only, returns ID_VALUE.
  - 0x01 SCRATCH: read/write, reset value 0.
  - 0x02 EVENT: sticky; bit i sets when EVENT_IN[i]=1; writing 1 clears the bit; reset value 0.
  - 0x03 EVENT_MASK: read/write, reset value 0.
  - 0x04..0x04+NUM_CTRL-1 CTRL[n]: read/write, reset value 0.
  - All other addresses: reads return 0; writes are accepted and discarded.
- Writes honour byte enables per byte. An access with BYTEEN=0 is still acknowledged and changes no state.
- EVENT register: in the same cycle, a set from EVENT_IN wins over a write-1 clear on the same bit. Writes to the ID register are ignored.
- FSM has three states:
  - IDLE: WAITREQUEST=1. On READ or WRITE, capture address, data, byte enables and command type. Go to WAIT if WAIT_CYCLES>0, otherwise go to ACK.
  - WAIT: 4-bit counter runs from WAIT_CYCLES-1 down to 0. At 0, go to ACK.
  - ACK: WAITREQUEST=0 for one cycle. A write commits in this cycle, using the captured fields. Go to IDLE unconditionally.
- READDATA is registered and loaded on the edge that enters ACK. It holds its value until the next read loads it.
- READ and WRITE asserted together is a protocol violation. The responder performs the read and drops the write.
- A master that deasserts its command mid-wait is also a violation. The responder completes the access using the captured fields.
- IRQ = |(EVENT & EVENT_MASK), registered, so it follows state by one cycle.

## Timing
- Reset values: WAITREQUEST=1, READDATA=0, CTRL_OUT=0, IRQ=0, FSM=IDLE, all registers 0.
- Access latency: command first seen in IDLE at cycle t; WAITREQUEST=0 at cycle t+1+WAIT_CYCLES.
  - WAIT_CYCLES=0: ack at t+1.
  - Default (WAIT_CYCLES=1): ack at t+2.
- Back-to-back accesses: after ACK the FSM is in IDLE at cycle ack+1. A command still asserted there starts a new access. Minimum spacing between acks is 2+WAIT_CYCLES.
- A written CTRL value appears on CTRL_OUT on the edge that ends the ACK cycle. IRQ reflects it one cycle later.
- Reset asserted mid-access: outputs return asynchronously to their reset values. The pending access is discarded; a pending write does not commit.

## Test plan
- Reset, then read 0x00 with WAIT_CYCLES=1: WAITREQUEST is low exactly 2 cycles after READ is first seen, and READDATA=32'h5EC0_0001.
- Write 0x01 with data 32'hA5A5_1234 and BYTEEN=4'b0101, then read 0x01: read returns 32'h00A5_0034.
- Pulse EVENT_IN=32'h0000_0003 for one cycle with EVENT_MASK=1: EVENT=3 and IRQ=1. Write 1 to 0x02 while EVENT_IN[0] pulses in the commit cycle: EVENT stays 3. A later write of 3 clears EVENT to 0, and IRQ falls one cycle later.
- Write 0x04=32'hDEAD_BEEF and 0x07=32'h1 (NUM_CTRL=4): CTRL_OUT=128'h0000_0001_0000_0000_0000_0000_DEAD_BEEF. Read of 0x08 returns 0. Write to 0x08 leaves all registers unchanged.
- Assert RESET_N low during the WAIT state of a write to 0x01: WAITREQUEST=1 immediately, and SCRATCH still reads 0 after reset is released.
- With WAIT_CYCLES=0, issue READ and WRITE together to 0x01: the read is acked at t+1 and SCRATCH is unchanged.

Source files
------------

// File: rtl/ctrl_plane_responder.sv
// ctrl_plane_responder
//
// Word-addressed Avalon-MM slave at the end of the control-plane path.
// It holds a small register file: ID, scratch, a sticky event latch
// (write-1-to-clear), an event mask and NUM_CTRL control words. Every
// access completes through a registered waitrequest handshake that adds
// WAIT_CYCLES wait states.
//
// Handshake: the master holds READ or WRITE together with its address,
// data and byte enables. The command stays pending while WAITREQUEST is
// high. It is accepted in the single cycle where WAITREQUEST is low. Any
// read data is valid in that same cycle. The responder captures the
// command when it first sees it, so a master that drops or changes the
// command mid-access still gets the originally captured access completed.
//
// Ports
//   CLOCK               in   rising-edge clock
//   RESET_N             in   asynchronous active-low reset
//   AVS_S0_READ         in   read request
//   AVS_S0_WRITE        in   write request (ignored when READ is also high)
//   AVS_S0_ADDRESS      in   [7:0] word address
//   AVS_S0_BYTEEN       in   [3:0] byte enables, writes only
//   AVS_S0_WRITEDATA    in   [31:0] write data
//   AVS_S0_READDATA     out  [31:0] registered read data
//   AVS_S0_WAITREQUEST  out  registered; low for one cycle = accepted
//   EVENT_IN            in   [31:0] event strobes, sampled every cycle
//   CTRL_OUT            out  [32*NUM_CTRL-1:0] control words, CTRL[0] in LSBs
//   IRQ                 out  registered |(EVENT & EVENT_MASK)
//   FSM_STATE           out  [1:0] handshake state: 0 idle, 1 wait, 2 ack

module ctrl_plane_responder #(
    parameter logic [31:0] ID_VALUE    = 32'h5EC0_0001,
    parameter int          WAIT_CYCLES = 1,
    parameter int          NUM_CTRL    = 4
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    input  logic                    AVS_S0_READ,
    input  logic                    AVS_S0_WRITE,
    input  logic [7:0]              AVS_S0_ADDRESS,
    input  logic [3:0]              AVS_S0_BYTEEN,
    input  logic [31:0]             AVS_S0_WRITEDATA,
    output logic [31:0]             AVS_S0_READDATA,
    output logic                    AVS_S0_WAITREQUEST,
    input  logic [31:0]             EVENT_IN,
    output logic [32*NUM_CTRL-1:0]  CTRL_OUT,
    output logic                    IRQ,
    output logic [1:0]              FSM_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;

    // Captured command
    logic [7:0]  cap_addr_q;
    logic [31:0] cap_data_q;
    logic [3:0]  cap_be_q;
    logic        cap_write_q;

    // Register file
    logic [31:0] scratch_q;
    logic [31:0] event_q;
    logic [31:0] mask_q;
    logic [31:0] ctrl_q [NUM_CTRL];

    logic [31:0] readdata_q;
    logic        waitreq_q;
    logic        irq_q;

    logic        cmd_seen;
    logic [7:0]  acc_addr;
    logic        acc_write;
    logic        enter_ack;
    logic        commit;
    logic [31:0] wr_mask;
    logic [31:0] event_clr;
    logic [31:0] rd_mux;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    assign cmd_seen = AVS_S0_READ | AVS_S0_WRITE;

    // In IDLE the access is being captured on this very edge, so the
    // live bus fields are the ones to use (matters for WAIT_CYCLES=0,
    // where IDLE goes straight to ACK). Later states use the capture.
    assign acc_addr  = (state_q == ST_IDLE) ? AVS_S0_ADDRESS : cap_addr_q;
    assign acc_write = (state_q == ST_IDLE) ? (AVS_S0_WRITE & ~AVS_S0_READ)
                                            : cap_write_q;

    assign enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK);
    assign commit    = (state_q == ST_ACK) && cap_write_q;
    assign wr_mask   = be_mask(cap_be_q);
    assign event_clr = (commit && cap_addr_q == 8'h02) ? (cap_data_q & wr_mask) : 32'h0;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_seen) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read mux over the register map
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = 32'h0;
        case (acc_addr)
            8'h00:   rd_mux = ID_VALUE;
            8'h01:   rd_mux = scratch_q;
            8'h02:   rd_mux = event_q;
            8'h03:   rd_mux = mask_q;
            default: rd_mux = 32'h0;
        endcase
        for (int n = 0; n < NUM_CTRL; n++) begin
            if (acc_addr == 8'(4 + n)) begin
                rd_mux = ctrl_q[n];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state, capture and handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            cap_addr_q  <= 8'h0;
            cap_data_q  <= 32'h0;
            cap_be_q    <= 4'h0;
            cap_write_q <= 1'b0;
            readdata_q  <= 32'h0;
            waitreq_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // Waitrequest is registered: it drops for the cycle spent in ACK.
            waitreq_q <= (state_d != ST_ACK);
            if (state_q == ST_IDLE && cmd_seen) begin
                cap_addr_q  <= AVS_S0_ADDRESS;
                cap_data_q  <= AVS_S0_WRITEDATA;
                cap_be_q    <= AVS_S0_BYTEEN;
                // A simultaneous read and write is served as a read.
                cap_write_q <= AVS_S0_WRITE & ~AVS_S0_READ;
            end
            if (enter_ack && !acc_write) begin
                readdata_q <= rd_mux;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file; writes commit at the edge that ends ACK
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            scratch_q <= 32'h0;
            event_q   <= 32'h0;
            mask_q    <= 32'h0;
            irq_q     <= 1'b0;
            for (int n = 0; n < NUM_CTRL; n++) begin
                ctrl_q[n] <= 32'h0;
            end
        end else begin
            // Clear first, then OR in new events so a set beats a clear.
            event_q <= (event_q & ~event_clr) | EVENT_IN;
            irq_q   <= |(event_q & mask_q);
            if (commit) begin
                if (cap_addr_q == 8'h01) begin
                    scratch_q <= (scratch_q & ~wr_mask) | (cap_data_q & wr_mask);
                end
                if (cap_addr_q == 8'h03) begin
                    mask_q <= (mask_q & ~wr_mask) | (cap_data_q & wr_mask);
                end
                for (int n = 0; n < NUM_CTRL; n++) begin
                    if (cap_addr_q == 8'(4 + n)) begin
                        ctrl_q[n] <= (ctrl_q[n] & ~wr_mask) | (cap_data_q & wr_mask);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
        assign CTRL_OUT[32*g +: 32] = ctrl_q[g];
    end

    assign AVS_S0_READDATA    = readdata_q;
    assign AVS_S0_WAITREQUEST = waitreq_q;
    assign IRQ                = irq_q;
    assign FSM_STATE          = state_q;

endmodule

// File: tb/tb_ctrl_plane_responder.sv
module tb_ctrl_plane_responder;

    localparam logic [31:0] ID = 32'h5EC0_0001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (WAIT_CYCLES=1) ----------------
    logic         rd_req, wr_req;
    logic [7:0]   address;
    logic [3:0]   byteen;
    logic [31:0]  writedata, readdata, event_in;
    logic         waitreq, irq;
    logic [127:0] ctrl_out;
    logic [1:0]   fsm_state;

    ctrl_plane_responder #(.ID_VALUE(ID), .WAIT_CYCLES(1), .NUM_CTRL(4)) dut (
        .CLOCK(clk), .RESET_N(rst_n),
        .AVS_S0_READ(rd_req), .AVS_S0_WRITE(wr_req),
        .AVS_S0_ADDRESS(address), .AVS_S0_BYTEEN(byteen),
        .AVS_S0_WRITEDATA(writedata), .AVS_S0_READDATA(readdata),
        .AVS_S0_WAITREQUEST(waitreq), .EVENT_IN(event_in),
        .CTRL_OUT(ctrl_out), .IRQ(irq), .FSM_STATE(fsm_state)
    );

    // ---------------- DUT (WAIT_CYCLES=0) ----------------
    logic         z_rd_req, z_wr_req;
    logic [7:0]   z_address;
    logic [31:0]  z_readdata;
    logic         z_waitreq, z_irq;
    logic [127:0] z_ctrl_out;
    logic [1:0]   z_fsm_state;

    ctrl_plane_responder #(.ID_VALUE(ID), .WAIT_CYCLES(0), .NUM_CTRL(4)) dut0 (
        .CLOCK(clk), .RESET_N(rst_n),
        .AVS_S0_READ(z_rd_req), .AVS_S0_WRITE(z_wr_req),
        .AVS_S0_ADDRESS(z_address), .AVS_S0_BYTEEN(byteen),
        .AVS_S0_WRITEDATA(writedata), .AVS_S0_READDATA(z_readdata),
        .AVS_S0_WAITREQUEST(z_waitreq), .EVENT_IN(event_in),
        .CTRL_OUT(z_ctrl_out), .IRQ(z_irq), .FSM_STATE(z_fsm_state)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_scratch, m_event, m_mask;
    logic [31:0] m_ctrl [4];

    task automatic m_reset();
        m_scratch = 0; m_event = 0; m_mask = 0;
        for (int i = 0; i < 4; i++) m_ctrl[i] = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int idx;
        idx = int'(a) - 4;
        if (a == 8'd0) return ID;
        if (a == 8'd1) return m_scratch;
        if (a == 8'd2) return m_event;
        if (a == 8'd3) return m_mask;
        if (idx >= 0 && idx < 4) return m_ctrl[idx];
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        int idx;
        idx = int'(a) - 4;
        if (a == 8'd1) m_scratch = m_merge(m_scratch, d, b);
        else if (a == 8'd2) m_event = m_event & ~m_merge(32'h0, d, b);
        else if (a == 8'd3) m_mask = m_merge(m_mask, d, b);
        else if (idx >= 0 && idx < 4) m_ctrl[idx] = m_merge(m_ctrl[idx], d, b);
    endtask

    function automatic logic [127:0] m_ctrl_out();
        return {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]};
    endfunction

    function automatic logic m_irq();
        return |(m_event & m_mask);
    endfunction

    // ---------------- driver ----------------
    // Presents one command, waits (bounded) for the ack, pulses EVENT_IN=ev
    // during the ack cycle, and returns one cycle after the commit edge.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] b, input logic [31:0] ev,
                          output logic [31:0] rdat, output int lat);
        logic acked;
        acked = 1'b0;
        lat = -1;
        rdat = 'x;
        @(posedge clk); #1;
        rd_req = rd; wr_req = wr; address = a; writedata = d; byteen = b;
        for (int k = 0; k < 40 && !acked; k++) begin
            @(negedge clk);
            if (waitreq === 1'b0) begin
                acked = 1'b1;
                lat = k;
                rdat = readdata;
            end
        end
        rd_req = 0; wr_req = 0;
        check("ack_seen", acked, 1'b1);
        event_in = ev;
        @(posedge clk); #1;
        event_in = 0;
        if (acked) begin
            if (wr && !rd) m_write(a, d, b);
            m_event = m_event | ev;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rdat, exp, d, ev;
        logic [7:0]  a;
        logic [3:0]  b;
        logic        irq_old;
        int          lat, op;

        rd_req = 0; wr_req = 0; address = 0; byteen = 0; writedata = 0; event_in = 0;
        z_rd_req = 0; z_wr_req = 0; z_address = 0;
        m_reset();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_waitreq", waitreq, 1'b1);
        check("rst_readdata", readdata, 32'h0);
        check("rst_ctrl_out", ctrl_out, 128'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_fsm_idle", fsm_state, 2'd0);
        rst_n = 1;

        // ID read and access latency
        access(1, 0, 8'h00, 0, 4'hF, 0, rdat, lat);
        check("id_latency", lat, 2);
        check("id_value", rdat, ID);

        // Byte-enabled scratch write
        access(0, 1, 8'h01, 32'hA5A5_1234, 4'b0101, 0, rdat, lat);
        check("wr_latency", lat, 2);
        access(1, 0, 8'h01, 0, 4'hF, 0, rdat, lat);
        check("scratch_be", rdat, 32'h00A5_0034);

        // BYTEEN=0 write is acked and changes nothing
        access(0, 1, 8'h01, 32'hFFFF_FFFF, 4'b0000, 0, rdat, lat);
        check("be0_latency", lat, 2);
        access(1, 0, 8'h01, 0, 4'hF, 0, rdat, lat);
        check("scratch_be0", rdat, 32'h00A5_0034);

        // ID is read-only
        access(0, 1, 8'h00, 32'h1234_5678, 4'hF, 0, rdat, lat);
        access(1, 0, 8'h00, 0, 4'hF, 0, rdat, lat);
        check("id_readonly", rdat, ID);

        // Events, mask and IRQ
        access(0, 1, 8'h03, 32'h1, 4'hF, 0, rdat, lat);
        @(posedge clk); #1; event_in = 32'h3;
        @(posedge clk); #1; event_in = 32'h0;
        m_event = m_event | 32'h3;
        check("irq_lags_event", irq, 1'b0);
        @(posedge clk); #1;
        check("irq_set", irq, 1'b1);
        access(1, 0, 8'h02, 0, 4'hF, 0, rdat, lat);
        check("event_latched", rdat, 32'h3);
        access(0, 1, 8'h02, 32'h1, 4'hF, 32'h1, rdat, lat);
        access(1, 0, 8'h02, 0, 4'hF, 0, rdat, lat);
        check("event_set_wins", rdat, 32'h3);
        access(0, 1, 8'h02, 32'h3, 4'hF, 0, rdat, lat);
        check("irq_holds_one_cycle", irq, 1'b1);
        @(posedge clk); #1;
        check("irq_cleared", irq, 1'b0);
        access(1, 0, 8'h02, 0, 4'hF, 0, rdat, lat);
        check("event_cleared", rdat, 32'h0);

        // Control registers and unmapped addresses
        access(0, 1, 8'h04, 32'hDEAD_BEEF, 4'hF, 0, rdat, lat);
        access(0, 1, 8'h07, 32'h1, 4'hF, 0, rdat, lat);
        check("ctrl_out", ctrl_out, 128'h0000_0001_0000_0000_0000_0000_DEAD_BEEF);
        access(1, 0, 8'h08, 0, 4'hF, 0, rdat, lat);
        check("unmapped_read", rdat, 32'h0);
        access(0, 1, 8'h08, 32'hFFFF_FFFF, 4'hF, 0, rdat, lat);
        check("unmapped_wr_ctrl", ctrl_out, 128'h0000_0001_0000_0000_0000_0000_DEAD_BEEF);
        for (int i = 0; i < 8; i++) begin
            exp = m_read(8'(i));
            access(1, 0, 8'(i), 0, 4'hF, 0, rdat, lat);
            check($sformatf("regmap_%0d", i), rdat, exp);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 80; i++) begin
            a  = 8'($urandom_range(0, 9));
            op = $urandom_range(0, 2);
            d  = $urandom;
            b  = 4'($urandom_range(0, 15));
            ev = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            exp = m_read(a);
            irq_old = m_irq();
            access(op == 0, op != 0, a, d, b, ev, rdat, lat);
            check("rand_latency", lat, 2);
            if (op == 0) check($sformatf("rand_read_%0h", a), rdat, exp);
            check("rand_ctrl_out", ctrl_out, m_ctrl_out());
            check("rand_irq_old", irq, irq_old);
            @(posedge clk); #1;
            check("rand_irq_new", irq, m_irq());
        end

        // Reset during WAIT of a scratch write
        @(posedge clk); #1;
        wr_req = 1; address = 8'h01; writedata = 32'h1357_9BDF; byteen = 4'hF;
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        wr_req = 0;
        check("rst_wait_waitreq", waitreq, 1'b1);
        check("rst_wait_fsm", fsm_state, 2'd0);
        check("rst_wait_ctrl", ctrl_out, 128'h0);
        m_reset();
        @(negedge clk); rst_n = 1;
        access(1, 0, 8'h01, 0, 4'hF, 0, rdat, lat);
        check("rst_wait_scratch", rdat, m_read(8'h01));

        // Reset during ACK of a scratch write: waitrequest returns high at once
        @(posedge clk); #1;
        wr_req = 1; address = 8'h01; writedata = 32'hCAFE_F00D; byteen = 4'hF;
        lat = -1;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (waitreq === 1'b0) lat = k;
        end
        check("ack_before_reset", lat, 2);
        rst_n = 0; wr_req = 0;
        #1;
        check("rst_ack_waitreq", waitreq, 1'b1);
        m_reset();
        @(negedge clk); rst_n = 1;
        access(1, 0, 8'h01, 0, 4'hF, 0, rdat, lat);
        check("rst_ack_scratch", rdat, 32'h0);

        // WAIT_CYCLES=0 instance: simultaneous read and write
        @(posedge clk); #1;
        z_rd_req = 1; z_wr_req = 1; z_address = 8'h01;
        writedata = 32'hFFFF_FFFF; byteen = 4'hF;
        @(negedge clk);
        check("z_t_waitreq", z_waitreq, 1'b1);
        @(negedge clk);
        check("z_t1_ack", z_waitreq, 1'b0);
        check("z_rw_readdata", z_readdata, 32'h0);
        z_rd_req = 0; z_wr_req = 0;
        @(posedge clk); #1;
        z_rd_req = 1; z_address = 8'h01;
        @(negedge clk);
        @(negedge clk);
        check("z_read_ack", z_waitreq, 1'b0);
        check("z_scratch_unchanged", z_readdata, 32'h0);
        z_rd_req = 0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
